// File: rtl/framebuf_pkg.sv
// Shared types and helpers for the double-buffered frame buffer.
package framebuf_pkg;

  // Swap request state: a requested swap waits here for the next vblank rise.
  typedef enum logic [0:0] {
    StIdle,
    StPending
  } swap_st_e;

  // Flat word address {bank, y, x}; row pitch is 2**h_bits.
  function automatic logic [31:0] pack_addr(input logic        bank,
                                            input logic [31:0] y,
                                            input logic [31:0] x,
                                            input int unsigned h_bits,
                                            input int unsigned v_bits);
    return ({31'd0, bank} << (h_bits + v_bits)) | (y << h_bits) | x;
  endfunction

  // True when (x, y) lies inside the visible H_ACTIVE x V_ACTIVE window.
  function automatic logic in_range(input logic [31:0] x,
                                    input logic [31:0] y,
                                    input int unsigned h_active,
                                    input int unsigned v_active);
    return (x < h_active) && (y < v_active);
  endfunction

endpackage

// File: rtl/framebuf_dbl_if.sv
// Pixel-writer / scan-out bundle of the double-buffered frame buffer.
interface framebuf_dbl_if #(
  parameter int unsigned H_BITS = 8,
  parameter int unsigned V_BITS = 8,
  parameter int unsigned PIX_W  = 8
);
  logic              wr_en;
  logic [H_BITS-1:0] wr_x;
  logic [V_BITS-1:0] wr_y;
  logic [PIX_W-1:0]  wr_data;
  logic              frame_done;
  logic              vblank;
  logic              rd_en;
  logic [H_BITS-1:0] rd_x;
  logic [V_BITS-1:0] rd_y;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_valid;
  logic              front_bank;
  logic              swap_pending;
  logic [7:0]        swap_drop_cnt;
  logic              clear_busy;

  // Core and video side.
  modport master (
    output wr_en, wr_x, wr_y, wr_data, frame_done, vblank, rd_en, rd_x, rd_y,
    input  rd_data, rd_valid, front_bank, swap_pending, swap_drop_cnt, clear_busy
  );

  // Frame buffer side.
  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, frame_done, vblank, rd_en, rd_x, rd_y,
    output rd_data, rd_valid, front_bank, swap_pending, swap_drop_cnt, clear_busy
  );
endinterface

// File: rtl/framebuf_clear.sv
// Back-bank clear engine: sweeps H_ACTIVE x V_ACTIVE, x fastest, one pixel per
// unstalled cycle. Only instantiated when FRAMEBUF_CLEAR_ON_SWAP_EN is defined.
module framebuf_clear #(
  parameter int unsigned H_BITS   = 8,
  parameter int unsigned V_BITS   = 8,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 256
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              we_o,
  output logic [H_BITS-1:0] x_o,
  output logic [V_BITS-1:0] y_o
);

  localparam logic [H_BITS-1:0] XLast = H_BITS'(H_ACTIVE - 1);
  localparam logic [V_BITS-1:0] YLast = V_BITS'(V_ACTIVE - 1);

  logic              busy_q, busy_d;
  logic [H_BITS-1:0] x_q, x_d;
  logic [V_BITS-1:0] y_q, y_d;

  // Next-state: restart at (0,0) on start, otherwise advance on each clear write.
  always_comb begin
    busy_d = busy_q;
    x_d    = x_q;
    y_d    = y_q;
    we_o   = busy_q & ~stall_i;
    if (start_i) begin
      busy_d = 1'b1;
      x_d    = '0;
      y_d    = '0;
    end else if (we_o) begin
      if (x_q == XLast) begin
        x_d = '0;
        if (y_q == YLast) begin
          busy_d = 1'b0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Counter and busy registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign busy_o = busy_q;
  assign x_o    = x_q;
  assign y_o    = y_q;

endmodule

// File: rtl/framebuf_dbl.sv
// Double-buffered pixel frame buffer. The core writes the back bank, scan-out
// reads the front bank; a requested swap commits only on a vblank rising edge.
// Optional clear-on-swap engine enabled by defining FRAMEBUF_CLEAR_ON_SWAP_EN.
module framebuf_dbl
  import framebuf_pkg::*;
#(
  parameter int unsigned      H_BITS   = 8,
  parameter int unsigned      V_BITS   = 8,
  parameter int unsigned      PIX_W    = 8,
  parameter int unsigned      H_ACTIVE = 256,
  parameter int unsigned      V_ACTIVE = 256,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input logic           clk_sys,
  input logic           reset_n,
  framebuf_dbl_if.slave bus
);

  localparam int unsigned ADDR_W = H_BITS + V_BITS + 1;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic [PIX_W-1:0] mem [DEPTH];

  swap_st_e         state_q, state_d;
  logic             front_bank_q, front_bank_d;
  logic [7:0]       drop_q, drop_d;
  logic             vblank_d_q;
  logic             vblank_rise;
  logic             swap_commit;
  logic             clear_busy;
  logic [PIX_W-1:0] rd_data_q;
  logic             rd_valid_q;

  logic              wr_in, rd_in;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [PIX_W-1:0]  mem_wdata;

  assign vblank_rise = bus.vblank & ~vblank_d_q;

  assign wr_in   = in_range(32'(bus.wr_x), 32'(bus.wr_y), H_ACTIVE, V_ACTIVE);
  assign rd_in   = in_range(32'(bus.rd_x), 32'(bus.rd_y), H_ACTIVE, V_ACTIVE);
  assign wr_addr = ADDR_W'(pack_addr(~front_bank_q, 32'(bus.wr_y), 32'(bus.wr_x),
                                     H_BITS, V_BITS));
  assign rd_addr = ADDR_W'(pack_addr(front_bank_q, 32'(bus.rd_y), 32'(bus.rd_x),
                                     H_BITS, V_BITS));

`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
  logic              clr_we;
  logic [H_BITS-1:0] clr_x;
  logic [V_BITS-1:0] clr_y;
  logic [ADDR_W-1:0] clr_addr;

  // Commit cannot happen while busy, so the current back bank is the one to clear.
  assign clr_addr = ADDR_W'(pack_addr(~front_bank_q, 32'(clr_y), 32'(clr_x),
                                      H_BITS, V_BITS));

  framebuf_clear #(
    .H_BITS  (H_BITS),
    .V_BITS  (V_BITS),
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_clear (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .start_i(swap_commit),
    .stall_i(bus.wr_en),
    .busy_o (clear_busy),
    .we_o   (clr_we),
    .x_o    (clr_x),
    .y_o    (clr_y)
  );
`else
  assign clear_busy = 1'b0;
`endif

  // Single write port: core writes win, clear engine fills idle cycles.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = bus.wr_data;
    if (bus.wr_en && wr_in) begin
      mem_we = 1'b1;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    end else if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = BG_COLOR;
`endif
    end
  end

  // Pixel storage, not reset.
  always_ff @(posedge clk_sys) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Swap FSM next-state, bank toggle and drop accounting.
  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    drop_d       = drop_q;
    swap_commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.frame_done) begin
          if (vblank_rise && !clear_busy) begin
            swap_commit = 1'b1;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (vblank_rise && !clear_busy) begin
          swap_commit = 1'b1;
          state_d     = StIdle;
        end else if (bus.frame_done && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (swap_commit) begin
      front_bank_d = ~front_bank_q;
    end
  end

  // Swap state, vblank edge detector and latency-1 read port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      front_bank_q <= 1'b0;
      drop_q       <= 8'd0;
      vblank_d_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      drop_q       <= drop_d;
      vblank_d_q   <= bus.vblank;
      rd_valid_q   <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_in ? mem[rd_addr] : BG_COLOR;
      end
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.front_bank    = front_bank_q;
  assign bus.swap_pending  = (state_q == StPending);
  assign bus.swap_drop_cnt = drop_q;
  assign bus.clear_busy    = clear_busy;

endmodule

// File: tb/tb_framebuf_dbl.sv
// Self-checking bench for framebuf_dbl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the buffer.
module tb_framebuf_dbl;

  localparam int unsigned HB = 5, VB = 5, PW = 8, HA = 16, VA = 16;
  localparam int unsigned PITCH = 32, BANKSZ = 1024;
  localparam logic [7:0]  BG = 8'h3C;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  framebuf_dbl_if #(.H_BITS(HB), .V_BITS(VB), .PIX_W(PW)) bus ();

  framebuf_dbl #(
    .H_BITS(HB), .V_BITS(VB), .PIX_W(PW), .H_ACTIVE(HA), .V_ACTIVE(VA), .BG_COLOR(BG)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state (post-edge values).
  logic [7:0]  m_mem   [2*BANKSZ];
  bit          m_known [2*BANKSZ];
  bit          m_front, m_pending, m_vb_prev, m_rd_valid, m_rd_known, m_clr_busy;
  int unsigned m_drop, m_clr_idx;
  logic [7:0]  m_rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ix(input bit b, input int unsigned x, input int unsigned y);
    return b * BANKSZ + y * PITCH + x;
  endfunction

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_vb_prev = 0; m_rd_valid = 0;
    m_rd_known = 1; m_rd_data = 8'h00; m_drop = 0; m_clr_busy = 0; m_clr_idx = 0;
  endtask

  // One clock of the buffer's rules, applied to the currently driven inputs.
  task automatic model_step();
    bit rise, want, commit;
    int unsigned a;
    rise   = bus.vblank && !m_vb_prev;
    want   = m_pending || bus.frame_done;
    commit = want && rise && !m_clr_busy;
    if (m_pending && bus.frame_done && !commit && m_drop < 255) m_drop++;
    m_pending  = want && !commit;
    m_rd_valid = bus.rd_en;
    if (bus.rd_en) begin
      if (bus.rd_x < HA && bus.rd_y < VA) begin
        a = ix(m_front, bus.rd_x, bus.rd_y);
        m_rd_data  = m_mem[a];
        m_rd_known = m_known[a];
      end else begin
        m_rd_data  = BG;
        m_rd_known = 1;
      end
    end
    if (bus.wr_en && bus.wr_x < HA && bus.wr_y < VA) begin
      a = ix(!m_front, bus.wr_x, bus.wr_y);
      m_mem[a]   = bus.wr_data;
      m_known[a] = 1;
    end
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    if (m_clr_busy && !bus.wr_en) begin
      a = ix(!m_front, m_clr_idx % HA, m_clr_idx / HA);
      m_mem[a]   = BG;
      m_known[a] = 1;
      m_clr_idx++;
      if (m_clr_idx == HA * VA) m_clr_busy = 0;
    end
    if (commit) begin
      m_clr_busy = 1;
      m_clr_idx  = 0;
    end
`endif
    if (commit) m_front = !m_front;
    m_vb_prev = bus.vblank;
  endtask

  task automatic check_all();
    chk("rd_valid", bus.rd_valid, m_rd_valid);
    chk("front_bank", bus.front_bank, m_front);
    chk("swap_pending", bus.swap_pending, m_pending);
    chk("swap_drop_cnt", bus.swap_drop_cnt, m_drop);
    chk("clear_busy", bus.clear_busy, m_clr_busy);
    if (m_rd_known) chk("rd_data", bus.rd_data, m_rd_data);
  endtask

  // Inputs are set at the falling edge; outputs checked at the next one.
  task automatic cyc();
    if (reset_n) model_step();
    else model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_all();
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.frame_done = 0; bus.rd_en = 0;
  endtask

  task automatic wr(input int unsigned x, input int unsigned y, input logic [7:0] d);
    bus.wr_en = 1; bus.wr_x = 5'(x); bus.wr_y = 5'(y); bus.wr_data = d;
  endtask

  task automatic rd(input int unsigned x, input int unsigned y);
    bus.rd_en = 1; bus.rd_x = 5'(x); bus.rd_y = 5'(y);
    cyc();
    bus.rd_en = 0;
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 600 && bus.clear_busy === 1'b1; i++) cyc();
    chk("clear_timeout", bus.clear_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit f;
    idle();
    bus.vblank = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_data = 0; bus.rd_x = 0; bus.rd_y = 0;
    for (int i = 0; i < 2 * BANKSZ; i++) m_known[i] = 0;
    model_reset();
    @(negedge clk_sys);
    chk("reset_front", bus.front_bank, 0);
    chk("reset_pending", bus.swap_pending, 0);
    chk("reset_drop", bus.swap_drop_cnt, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    chk("reset_rd_valid", bus.rd_valid, 0);
    chk("reset_busy", bus.clear_busy, 0);
    cyc(); cyc();
    reset_n = 1;

    // Basic write, request, deferred swap at vblank, read back.
    wr(3, 5, 8'hA5); cyc(); idle();
    bus.frame_done = 1; cyc(); bus.frame_done = 0;
    chk("pend_after_fd", bus.swap_pending, 1);
    repeat (10) cyc();
    bus.vblank = 1; cyc();
    chk("front_after_swap", bus.front_bank, 1);
    chk("pend_after_swap", bus.swap_pending, 0);
    rd(3, 5);
    chk("rd_a5", bus.rd_data, 8'hA5);
    chk("rd_valid_a5", bus.rd_valid, 1);
    cyc();
    chk("rd_valid_low", bus.rd_valid, 0);
    chk("rd_hold", bus.rd_data, 8'hA5);
    bus.vblank = 0; cyc();
    wait_clear();

    // frame_done on the vblank rise from idle, with a write in the swap cycle.
    bus.vblank = 1; bus.frame_done = 1; wr(7, 7, 8'h77); cyc(); idle();
    chk("fd_on_rise_front", bus.front_bank, 0);
    chk("fd_on_rise_pend", bus.swap_pending, 0);
    rd(7, 7);
    chk("swap_cycle_write", bus.rd_data, 8'h77);
    bus.vblank = 0; cyc();
    wait_clear();

    // Drop accounting and saturation.
    repeat (3) begin bus.frame_done = 1; cyc(); bus.frame_done = 0; cyc(); end
    chk("drop_two", bus.swap_drop_cnt, 2);
    bus.vblank = 1; cyc();
    chk("drop_swap_front", bus.front_bank, 1);
    chk("drop_swap_pend", bus.swap_pending, 0);
    bus.vblank = 0; cyc();
    wait_clear();
    bus.frame_done = 1; repeat (300) cyc(); bus.frame_done = 0;
    chk("drop_sat", bus.swap_drop_cnt, 255);
    bus.vblank = 1; cyc();
    chk("sat_swap_front", bus.front_bank, 0);
    bus.vblank = 0; cyc();
    wait_clear();

    // Out-of-range writes and reads.
    wr(20, 3, 8'h11); cyc(); wr(4, 20, 8'h22); cyc(); wr(4, 3, 8'h44); cyc(); idle();
    bus.frame_done = 1; bus.vblank = 1; cyc(); idle();
    rd(20, 3); chk("oor_x_read", bus.rd_data, BG);
    rd(4, 20); chk("oor_y_read", bus.rd_data, BG);
    rd(4, 3);  chk("inrange_read", bus.rd_data, 8'h44);
    bus.vblank = 0; cyc();
    wait_clear();

    // Reset while a swap is pending.
    bus.frame_done = 1; cyc(); bus.frame_done = 0;
    chk("pend_before_reset", bus.swap_pending, 1);
    reset_n = 0; #1;
    chk("reset_mid_pend", bus.swap_pending, 0);
    chk("reset_mid_front", bus.front_bank, 0);
    chk("reset_mid_drop", bus.swap_drop_cnt, 0);
    cyc();
    reset_n = 1;

`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    // Unstalled clear length.
    bus.frame_done = 1; bus.vblank = 1; cyc(); idle();
    n = 0;
    for (int i = 0; i < 600 && bus.clear_busy === 1'b1; i++) begin n++; cyc(); end
    chk("clear_len", n, 256);
    bus.vblank = 0; cyc();

    // Clear stretched by four core writes.
    bus.frame_done = 1; bus.vblank = 1; cyc(); idle();
    n = 0;
    for (int i = 0; i < 600 && bus.clear_busy === 1'b1; i++) begin
      if (n == 5)  wr(15, 15, 8'h5A);
      if (n == 15) wr(0, 0, 8'hC3);
      if (n == 25) wr(8, 8, 8'h81);
      if (n == 35) wr(1, 0, 8'h99);
      n++; cyc(); idle();
    end
    chk("clear_len_stall", n, 260);
    bus.vblank = 0; cyc();
    bus.frame_done = 1; bus.vblank = 1; cyc(); idle();
    rd(15, 15); chk("early_write_cleared", bus.rd_data, BG);
    rd(0, 0);   chk("late_write_kept", bus.rd_data, 8'hC3);

    // Swap deferred by an active clear.
    bus.vblank = 0; cyc();
    bus.frame_done = 1; cyc(); bus.frame_done = 0;
    f = m_front;
    bus.vblank = 1; cyc();
    chk("deferred_pend", bus.swap_pending, 1);
    chk("deferred_front", bus.front_bank, f);
    bus.vblank = 0; cyc();
    wait_clear();
    bus.vblank = 1; cyc();
    chk("deferred_commit_pend", bus.swap_pending, 0);
    chk("deferred_commit_front", bus.front_bank, !f);

    // Reset during a clear.
    repeat (5) cyc();
    reset_n = 0; #1;
    chk("busy_async_reset", bus.clear_busy, 0);
    cyc();
    reset_n = 1;
    bus.vblank = 0; cyc();
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.wr_x       = 5'($urandom_range(0, 19));
      bus.wr_y       = 5'($urandom_range(0, 19));
      bus.wr_data    = 8'($urandom);
      bus.rd_en      = 1'($urandom_range(0, 1));
      bus.rd_x       = 5'($urandom_range(0, 19));
      bus.rd_y       = 5'($urandom_range(0, 19));
      bus.frame_done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) bus.vblank = ~bus.vblank;
      // Keep clear of a fresh request landing on the commit cycle of a pending one.
      if (m_pending && bus.vblank && !m_vb_prev && !m_clr_busy) bus.frame_done = 0;
      cyc();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framebuf_dbl.md
Name: framebuf_dbl

Overview:
- Parametrised double-buffered pixel frame buffer between a core's pixel writer and the video scan-out.
- Core writes pixels by coordinate into the back bank. Video reads by hcount/vcount from the front bank.
- Bank swap is requested by the core's end-of-frame pulse and committed only at the start of display vblank, so scan-out never tears.
- Successor to the inline ping-pong VRAM: generic geometry and pixel width, fully synchronous swap, swap-drop accounting, optional clear engine.

Parameters:
- H_BITS, 8, x-coordinate width; row pitch is 2**H_BITS.
- V_BITS, 8, y-coordinate width.
- PIX_W, 8, pixel width in bits.
- H_ACTIVE, 256, writable/readable columns; x >= H_ACTIVE is out of range.
- V_ACTIVE, 256, writable/readable rows; y >= V_ACTIVE is out of range.
- BG_COLOR, 0, PIX_W value returned for out-of-range reads and used by the clear engine.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  pixel write strobe.
- wr_x  in  H_BITS  write column.
- wr_y  in  V_BITS  write row.
- wr_data  in  PIX_W  write pixel.
- frame_done  in  1  one-cycle pulse from core: back bank complete, request swap.
- vblank  in  1  display vertical blank level.
- rd_en  in  1  scan-out read strobe.
- rd_x  in  H_BITS  read column.
- rd_y  in  V_BITS  read row.
- rd_data  out  PIX_W  read pixel.
- rd_valid  out  1  rd_data updated this cycle.
- front_bank  out  1  bank currently displayed.
- swap_pending  out  1  swap requested, not yet committed.
- swap_drop_cnt  out  8  saturating count of requests dropped while pending.
- clear_busy  out  1  clear engine active (0 when feature absent).

Behaviour:
- Storage: single array of 2*2**(H_BITS+V_BITS) words of PIX_W; address = {bank, y, x}. Contents are not reset.
- Reset (async assert, sync release): front_bank=0, swap_pending=0, swap_drop_cnt=0, rd_data=0, rd_valid=0, clear_busy=0, internal vblank_d=0.
- Write path: if wr_en and in range, mem[{~front_bank, wr_y, wr_x}] <= wr_data. Out-of-range writes are silently discarded.
- Read path, latency 1: rd_valid <= rd_en. When rd_en, rd_data <= mem[{front_bank, rd_y, rd_x}], or BG_COLOR if out of range. When !rd_en, rd_data holds its value.
- vblank_rise = vblank & ~vblank_d; vblank_d is registered every cycle.
- Swap FSM, states IDLE/PENDING (swap_pending = PENDING):
  - IDLE + frame_done + vblank_rise (+ !clear_busy): swap that cycle, stay IDLE.
  - IDLE + frame_done otherwise: go to PENDING.
  - PENDING + vblank_rise + !clear_busy: front_bank toggles, go to IDLE.
  - PENDING + vblank_rise while clear_busy: stay PENDING; commit at the next vblank_rise with clear done.
  - PENDING + frame_done (no commit that cycle): request dropped, swap_drop_cnt += 1, saturating at 255.
- Same-cycle swap ordering: a write and a read in the swap cycle both use the pre-swap front_bank.
- reset_n asserted mid-pending or mid-clear aborts immediately and returns to reset values.

Optional Feature:
- Macro FRAMEBUF_CLEAR_ON_SWAP_EN.
- Defined:
  - On every committed swap, the clear engine starts at (0,0) of the new back bank and writes BG_COLOR one pixel per cycle, x fastest, over H_ACTIVE x V_ACTIVE.
  - A cycle with wr_en high is a core write: the clear engine stalls and the core write wins.
  - clear_busy is high from the cycle after the swap until the cycle after the last clear write.
  - Pixels the core writes before the clear reaches them are overwritten with BG_COLOR.
- Undefined: no clear engine; clear_busy tied 0; back bank keeps stale contents.

Decomposition:
- Package framebuf_pkg: swap FSM state enum (IDLE, PENDING); address-packing function {bank,y,x}; in-range check function.
- One natural sub-module: framebuf_clear (x/y counters, busy flag, stall input), instantiated only under the macro.

Test Plan:
- After reset, write (3,5)=0xA5 then frame_done; raise vblank 10 cycles later -> swap_pending 1 until vblank_rise, front_bank 0->1; reading (3,5) returns 0xA5 one cycle after rd_en, rd_valid 1.
- frame_done exactly on the vblank_rise cycle from IDLE -> front_bank toggles that cycle; swap_pending never asserts.
- Three frame_done pulses before any vblank_rise -> swap_drop_cnt=2, exactly one swap at the next vblank_rise; 300 drops -> swap_drop_cnt saturates at 255.
- H_ACTIVE=200: write x=220 -> memory unchanged; read x=220 -> rd_data=BG_COLOR.
- Write to pixel (7,7) in the swap cycle -> data lands in the old back bank, now the front bank, and reads back as the written value.
- With FRAMEBUF_CLEAR_ON_SWAP_EN, 16x16 geometry: after a swap, clear_busy high for 256 cycles plus stalled cycles; 4 interleaved wr_en cycles extend it to 260; a vblank_rise during the clear with a pending swap is deferred; reset_n low mid-clear -> clear_busy 0 asynchronously.
